icache_fill_ctrl: RTL and testbench
===================================

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per cache line (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port instr_miss_f_i  input  1  fetch-stage instruction cache lookup miss.
REQ-006 SHALL have port pc_f_i  input  ADDR_W  fetch PC of the missing access.
REQ-007 SHALL have port redirect_e_i  input  1  execute-stage PC redirect (branch mispredict).
REQ-008 SHALL have port mem_req_o  output  1  burst read request to memory.
REQ-009 SHALL have port mem_addr_o  output  ADDR_W  line-aligned burst base address.
REQ-010 SHALL have port mem_ready_i  input  1  memory accepts the request this cycle.
REQ-011 SHALL have port mem_rvalid_i  input  1  read beat valid.
REQ-012 SHALL have port mem_rdata_i  input  32  read beat data.
REQ-013 SHALL have port rep_en_o  output  1  one-cycle line replace strobe to cache and hazard unit.
REQ-014 SHALL have port line_addr_o  output  ADDR_W  line-aligned address of the replaced line.
REQ-015 SHALL have port line_data_o  output  32*LINE_WORDS  assembled line, word 0 in bits [31:0].
REQ-016 SHALL have port busy_o  output  1  fill in progress (any state except IDLE).
REQ-017 SHALL have port miss_cnt_o  output  16  saturating count of fills started.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, FILL, COMMIT.
REQ-019 IDLE: instr_miss_f_i=1 SHALL latch pc_f_i with low log2(LINE_WORDS)+2 bits cleared as line address, increment miss_cnt_o, and enter REQ next cycle.
REQ-020 REQ: mem_req_o SHALL be 1 and mem_addr_o SHALL equal the latched line address; mem_addr_o SHALL stay stable until acceptance.
REQ-021 REQ: mem_ready_i=1 SHALL enter FILL and clear the beat counter; mem_req_o SHALL deassert the following cycle.
REQ-022 REQ: redirect_e_i=1 with mem_ready_i=0 SHALL abandon the request, return to IDLE, and produce no rep_en_o.
REQ-023 REQ: redirect_e_i=1 and mem_ready_i=1 in the same cycle SHALL treat the request as accepted (enter FILL).
REQ-024 FILL: each mem_rvalid_i=1 SHALL write mem_rdata_i into word[beat] of the line buffer and increment the beat counter.
REQ-025 FILL: the beat with beat counter = LINE_WORDS-1 SHALL enter COMMIT next cycle; the counter SHALL not wrap beyond LINE_WORDS-1.
REQ-026 FILL: redirect_e_i SHALL NOT abort the burst; all LINE_WORDS beats SHALL be received and the line committed.
REQ-027 COMMIT: rep_en_o SHALL be 1 for exactly one cycle with line_addr_o/line_data_o valid; next state IDLE.
REQ-028 Latency: rep_en_o SHALL assert exactly one cycle after the last beat's rvalid cycle.
REQ-029 instr_miss_f_i SHALL be ignored in REQ, FILL and COMMIT; a miss present in the cycle after COMMIT (back in IDLE) SHALL start a new fill.
REQ-030 mem_rvalid_i SHALL be ignored in IDLE, REQ and COMMIT (no buffer write, no count).
REQ-031 miss_cnt_o SHALL saturate at 16'hFFFF.
REQ-032 line_data_o and line_addr_o SHALL hold their last values outside COMMIT.

Reset
REQ-033 reset_n_i=0 SHALL immediately force IDLE, mem_req_o=0, rep_en_o=0, busy_o=0, beat counter=0, miss_cnt_o=0, line_addr_o=0, line_data_o=0.
REQ-034 Reset asserted mid-REQ or mid-FILL SHALL discard the partial line; no rep_en_o SHALL follow reset release without a new miss.

Verification
REQ-035 Basic fill: miss with pc_f_i=0x0000_1234, ready next cycle, beats 0xA0..0xA3 back-to-back -> mem_addr_o=0x0000_1230, rep_en_o one cycle after beat 3, line_data_o={0xA3,0xA2,0xA1,0xA0}, miss_cnt_o=1.
REQ-036 Gapped beats: rvalid with 2-cycle gaps -> same line data, rep_en_o exactly one pulse, busy_o=1 throughout until COMMIT ends.
REQ-037 Redirect in REQ: mem_ready_i held 0 for 3 cycles, redirect_e_i=1 -> IDLE next cycle, no rep_en_o, miss_cnt_o=1; redirect with simultaneous ready -> full fill completes.
REQ-038 Redirect in FILL after beat 1 -> remaining beats captured, rep_en_o asserted, line committed intact.
REQ-039 Async reset after beat 2 -> outputs zero immediately; subsequent beats ignored; no rep_en_o until a new miss completes.
REQ-040 Back-to-back misses: instr_miss_f_i held 1 across COMMIT -> second fill starts the cycle after COMMIT, miss_cnt_o=2; counter preloaded near 0xFFFF stays at 0xFFFF.

Source files
------------

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache line fill controller: latches a fetch miss, issues one burst
// read, assembles LINE_WORDS beats into a line and strobes it into the cache.
module icache_fill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     instr_miss_f_i,
    input  logic [ADDR_W-1:0]        pc_f_i,
    input  logic                     redirect_e_i,
    output logic                     mem_req_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic                     mem_ready_i,
    input  logic                     mem_rvalid_i,
    input  logic [31:0]              mem_rdata_i,
    output logic                     rep_en_o,
    output logic [ADDR_W-1:0]        line_addr_o,
    output logic [32*LINE_WORDS-1:0] line_data_o,
    output logic                     busy_o,
    output logic [15:0]              miss_cnt_o
);
    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = BEAT_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_W-1:0]              req_addr_q, req_addr_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic [LINE_WORDS-1:0][31:0]    buf_q, buf_d;
    logic [ADDR_W-1:0]              line_addr_q, line_addr_d;
    logic [LINE_WORDS-1:0][31:0]    line_data_q, line_data_d;
    logic [15:0]                    miss_cnt_q, miss_cnt_d;
    logic                           last_beat;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign last_beat = (beat_q == LAST_BEAT);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            beat_q      <= '0;
            buf_q       <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            beat_q      <= beat_d;
            buf_q       <= buf_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // A redirect only cancels a request memory has not yet taken; once accepted the burst must drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_miss_f_i) state_d = REQ;
            REQ: begin
                if (mem_ready_i)       state_d = FILL;
                else if (redirect_e_i) state_d = IDLE;
            end
            FILL:    if (mem_rvalid_i && last_beat) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_addr_d  = req_addr_q;
        miss_cnt_d  = miss_cnt_q;
        beat_d      = beat_q;
        buf_d       = buf_q;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        if (state_q == IDLE && instr_miss_f_i) begin
            req_addr_d = pc_f_i & LINE_MASK;
            miss_cnt_d = sat_inc(miss_cnt_q);
        end
        if (state_q == REQ && mem_ready_i) begin
            beat_d = '0;
        end
        // The final beat is merged straight into the published line so it is valid during COMMIT.
        if (state_q == FILL && mem_rvalid_i) begin
            buf_d[beat_q] = mem_rdata_i;
            if (last_beat) begin
                line_data_d = buf_d;
                line_addr_d = req_addr_q;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_comb begin
        mem_req_o = (state_q == REQ);
        rep_en_o  = (state_q == COMMIT);
        busy_o    = (state_q != IDLE);
    end

    assign mem_addr_o  = req_addr_q;
    assign line_addr_o = line_addr_q;
    assign line_data_o = line_data_q;
    assign miss_cnt_o  = miss_cnt_q;
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: a vector table for the main flow plus
// hand-written sequences for gapped beats, async reset, back-to-back misses and saturation.
module tb_icache_fill_ctrl;
    logic         clk = 1'b0;
    logic         reset_n_i;
    logic         instr_miss_f_i;
    logic [31:0]  pc_f_i;
    logic         redirect_e_i;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;
    logic         rep_en_o;
    logic [31:0]  line_addr_o;
    logic [127:0] line_data_o;
    logic         busy_o;
    logic [15:0]  miss_cnt_o;

    int total = 0;
    int bad   = 0;

    icache_fill_ctrl #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .instr_miss_f_i(instr_miss_f_i),
        .pc_f_i(pc_f_i), .redirect_e_i(redirect_e_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .rep_en_o(rep_en_o), .line_addr_o(line_addr_o),
        .line_data_o(line_data_o), .busy_o(busy_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         miss;
        logic [31:0]  pc;
        logic         redir;
        logic         ready;
        logic         rvalid;
        logic [31:0]  rdata;
        logic         req;
        logic [31:0]  addr;
        logic         rep;
        logic         busy;
        logic [15:0]  cnt;
        logic [31:0]  laddr;
        logic [127:0] ldata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic miss, input logic [31:0] pc, input logic redir,
                                input logic ready, input logic rvalid, input logic [31:0] rdata,
                                input logic req, input logic [31:0] addr, input logic rep,
                                input logic busy, input logic [15:0] cnt,
                                input logic [31:0] laddr, input logic [127:0] ldata);
        vec_t v;
        v.miss = miss; v.pc = pc; v.redir = redir; v.ready = ready; v.rvalid = rvalid;
        v.rdata = rdata; v.req = req; v.addr = addr; v.rep = rep; v.busy = busy;
        v.cnt = cnt; v.laddr = laddr; v.ldata = ldata;
        return v;
    endfunction

    function automatic logic [127:0] mkline(input logic [31:0] d0);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = d0 + 32'(i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic rep, input logic busy, input logic [15:0] cnt,
                           input logic [31:0] laddr, input logic [127:0] ldata);
        chk({tag, ".req"},   128'(mem_req_o),   128'(req));
        chk({tag, ".addr"},  128'(mem_addr_o),  128'(addr));
        chk({tag, ".rep"},   128'(rep_en_o),    128'(rep));
        chk({tag, ".busy"},  128'(busy_o),      128'(busy));
        chk({tag, ".cnt"},   128'(miss_cnt_o),  128'(cnt));
        chk({tag, ".laddr"}, 128'(line_addr_o), 128'(laddr));
        chk({tag, ".ldata"}, line_data_o,       ldata);
    endtask

    task automatic idle_inputs();
        instr_miss_f_i = 1'b0; pc_f_i = '0; redirect_e_i = 1'b0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic start_miss(input logic [31:0] pc);
        instr_miss_f_i = 1'b1; pc_f_i = pc;
        tick();
        instr_miss_f_i = 1'b0;
    endtask

    // Drives acceptance and all four beats from REQ, then checks the commit cycle and return to IDLE.
    task automatic finish_fill(input string tag, input logic [31:0] d0, input logic [31:0] laddr);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = d0 + 32'(i);
            tick();
        end
        mem_rvalid_i = 1'b0;
        chk({tag, ".rep"},   128'(rep_en_o),    128'(1'b1));
        chk({tag, ".laddr"}, 128'(line_addr_o), 128'(laddr));
        chk({tag, ".ldata"}, line_data_o,       mkline(d0));
        tick();
        chk({tag, ".rep_off"},  128'(rep_en_o), 128'(1'b0));
        chk({tag, ".busy_off"}, 128'(busy_o),   128'(1'b0));
    endtask

    initial begin
        logic [127:0] z, d1, d2;
        vec_t v;
        z  = '0;
        d1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        d2 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

        vecs.push_back(mk(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h1230, 1'b0, 1'b1, 16'd1, 32'h0, z));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b0, 32'h1230, 1'b0, 1'b1, 16'd1, 32'h0, z));
        vecs.push_back(mk(1'b1, 32'h7777, 1'b0, 1'b0, 1'b1, 32'hA0,   1'b0, 32'h1230, 1'b0, 1'b1, 16'd1, 32'h0, z));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hA1,   1'b0, 32'h1230, 1'b0, 1'b1, 16'd1, 32'h0, z));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hA2,   1'b0, 32'h1230, 1'b0, 1'b1, 16'd1, 32'h0, z));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hA3,   1'b0, 32'h1230, 1'b1, 1'b1, 16'd1, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hBAD,  1'b0, 32'h1230, 1'b0, 1'b0, 16'd1, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hBAD2, 1'b0, 32'h1230, 1'b0, 1'b0, 16'd1, 32'h1230, d1));
        vecs.push_back(mk(1'b1, 32'h5678, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h5670, 1'b0, 1'b1, 16'd2, 32'h1230, d1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h5670, 1'b0, 1'b1, 16'd2, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h5670, 1'b0, 1'b0, 16'd2, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h5670, 1'b0, 1'b0, 16'd2, 32'h1230, d1));
        vecs.push_back(mk(1'b1, 32'h9ABC, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 32'h9AB0, 1'b0, 1'b1, 16'd3, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h9AB0, 1'b0, 1'b1, 16'd3, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hB0,   1'b0, 32'h9AB0, 1'b0, 1'b1, 16'd3, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hB1,   1'b0, 32'h9AB0, 1'b0, 1'b1, 16'd3, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h9AB0, 1'b0, 1'b1, 16'd3, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'hB2,   1'b0, 32'h9AB0, 1'b0, 1'b1, 16'd3, 32'h1230, d1));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hB3,   1'b0, 32'h9AB0, 1'b1, 1'b1, 16'd3, 32'h9AB0, d2));
        vecs.push_back(mk(1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h9AB0, 1'b0, 1'b0, 16'd3, 32'h9AB0, d2));

        idle_inputs();
        reset_n_i = 1'b0;
        tick(); tick();
        chk_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, z);
        #2 reset_n_i = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            instr_miss_f_i = v.miss; pc_f_i = v.pc; redirect_e_i = v.redir;
            mem_ready_i = v.ready; mem_rvalid_i = v.rvalid; mem_rdata_i = v.rdata;
            tick();
            chk_all($sformatf("vec%0d", i), v.req, v.addr, v.rep, v.busy, v.cnt, v.laddr, v.ldata);
        end
        idle_inputs();

        // Gapped beats: two idle cycles before every beat.
        start_miss(32'h2000_004C);
        chk("gap.addr", 128'(mem_addr_o), 128'(32'h2000_0040));
        chk("gap.cnt",  128'(miss_cnt_o), 128'(16'd4));
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 2; g++) begin
                tick();
                chk($sformatf("gap.b%0d.g%0d.busy", b, g), 128'(busy_o),   128'(1'b1));
                chk($sformatf("gap.b%0d.g%0d.rep", b, g),  128'(rep_en_o), 128'(1'b0));
            end
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC0 + 32'(b);
            tick();
            mem_rvalid_i = 1'b0;
            chk($sformatf("gap.b%0d.rep", b), 128'(rep_en_o), 128'(b == 3));
            chk($sformatf("gap.b%0d.busy", b), 128'(busy_o), 128'(1'b1));
        end
        chk("gap.ldata", line_data_o, mkline(32'hC0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("gap.after%0d.rep", i),  128'(rep_en_o), 128'(1'b0));
            chk($sformatf("gap.after%0d.busy", i), 128'(busy_o),   128'(1'b0));
        end

        // Asynchronous reset in the middle of a fill, after beat 2.
        start_miss(32'h0000_8008);
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hD0 + 32'(i);
            tick();
        end
        mem_rvalid_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #1;
        chk_all("arst", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, z);
        tick();
        #2 reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hD3 + 32'(i);
            tick();
            chk_all($sformatf("arst.post%0d", i), 1'b0, 32'h0, 1'b0, 1'b0, 16'd0, 32'h0, z);
        end
        mem_rvalid_i = 1'b0;
        start_miss(32'h0000_8008);
        chk("arst.refill.cnt", 128'(miss_cnt_o), 128'(16'd1));
        finish_fill("arst.refill", 32'hE0, 32'h0000_8000);

        // Back-to-back misses with the miss held through COMMIT.
        #2 reset_n_i = 1'b0;
        tick();
        #2 reset_n_i = 1'b1;
        instr_miss_f_i = 1'b1; pc_f_i = 32'h4000_0014;
        tick();
        chk("b2b.cnt1", 128'(miss_cnt_o), 128'(16'd1));
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hF0 + 32'(i);
            tick();
        end
        mem_rvalid_i = 1'b0;
        chk("b2b.rep",       128'(rep_en_o),   128'(1'b1));
        chk("b2b.ldata",     line_data_o,      mkline(32'hF0));
        chk("b2b.cnt_commit", 128'(miss_cnt_o), 128'(16'd1));
        tick();
        chk("b2b.idle.busy", 128'(busy_o),   128'(1'b0));
        chk("b2b.idle.rep",  128'(rep_en_o), 128'(1'b0));
        tick();
        instr_miss_f_i = 1'b0;
        chk("b2b.req2",  128'(mem_req_o),  128'(1'b1));
        chk("b2b.cnt2",  128'(miss_cnt_o), 128'(16'd2));
        chk("b2b.addr2", 128'(mem_addr_o), 128'(32'h4000_0010));
        finish_fill("b2b.fill2", 32'h50, 32'h4000_0010);

        // Saturation of the miss counter from a preloaded value.
        force dut.miss_cnt_q = 16'hFFFE;
        tick();
        release dut.miss_cnt_q;
        start_miss(32'h0000_0100);
        chk("sat.cnt1", 128'(miss_cnt_o), 128'(16'hFFFF));
        finish_fill("sat.fill1", 32'h60, 32'h0000_0100);
        start_miss(32'h0000_0200);
        chk("sat.cnt2", 128'(miss_cnt_o), 128'(16'hFFFF));
        finish_fill("sat.fill2", 32'h70, 32'h0000_0200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
